led_matrix_scan_driver: RTL and testbench
=========================================

// Module: led_matrix_scan_driver
// PURPOSE
//  Consumer end of the 8x8 RGB game-board interface: takes the packed board[7:0][23:0] frame
//  (per row: [7:0] blue, [15:8] green, [23:16] red) and scans it onto the LED matrix.
//  Each row is shifted serially into an external 24-bit '595-style chain, latched, then
//  displayed for a fixed hold time. Sits between the game logic and the matrix pins.
// PARAMETERS
//  CLK_DIV   2     clk cycles per half-period of sh_cp/st_cp (>=1)
//  ROW_HOLD  1000  clk cycles a latched row is lit (>=1)
// PORTS
//  clk         in   1    system clock; all logic on posedge
//  reset       in   1    synchronous, active-high reset
//  enable      in   1    1 = scan continuously; 0 = stop after current row
//  board       in   192  packed [7:0][23:0] frame from game logic
//  ds          out  1    serial data to shift chain
//  sh_cp       out  1    shift clock to chain (data sampled on rising edge)
//  st_cp       out  1    storage/latch clock to chain
//  oe_n        out  1    chain output enable, active-low (1 = blanked)
//  row_en      out  8    one-hot row drive, active-high
//  frame_start out  1    1-cycle pulse when a new frame snapshot is taken
// BEHAVIOUR
//  Reset: state IDLE, row=0, ds=0, sh_cp=0, st_cp=0, oe_n=1, row_en=0, frame_start=0.
//  Reset has priority over everything; asserted mid-operation -> reset values on next edge.
//  FSM: IDLE -> LOAD -> SHIFT -> LATCH -> HOLD -> LOAD | IDLE.
//  IDLE : outputs at reset values; enable=1 -> LOAD, row=0.
//  LOAD (1 cycle): if row==0, copy board into internal frame reg and pulse frame_start.
//   Load 24-bit shift reg with frame[row]; bit counter=23.
//  SHIFT: per bit, ds=current bit, held stable for 2*CLK_DIV cycles: sh_cp low for
//   CLK_DIV cycles, then high for CLK_DIV cycles. Order: bit 23 first, bit 0 last.
//   After 24th bit (48*CLK_DIV cycles) -> LATCH with sh_cp=0.
//  LATCH: st_cp=1 for CLK_DIV cycles, then 0 -> HOLD.
//  HOLD : oe_n=0, row_en=1<<row for ROW_HOLD cycles. At end: row=row+1 (7 wraps to 0);
//   enable=1 -> LOAD; enable=0 -> IDLE with row=0.
//  oe_n=1 and row_en=0 in every state except HOLD (no ghosting while shifting).
//  ds=0 outside SHIFT; st_cp=0 outside LATCH; sh_cp=0 outside SHIFT.
//  Row period = 1 + 49*CLK_DIV + ROW_HOLD cycles (defaults: 1099); frame = 8 row periods.
//  board is sampled only at LOAD of row 0: mid-frame changes never tear a frame.
//  enable dropped mid-row: current row finishes through HOLD, then IDLE; next enable
//   restarts at row 0 with a fresh snapshot and frame_start pulse.
//  enable sampled only in IDLE and at end of HOLD.
// TESTING
//  1 Reset held 3 cycles, enable=1 -> all outputs at reset values; release -> frame_start
//    pulse 2 cycles after reset falls (IDLE->LOAD), oe_n stays 1 until HOLD.
//  2 board[0]=24'h800001, others 0, defaults -> ds sampled at 24 sh_cp rises = 1,22x0,1;
//    one st_cp pulse 2 cycles wide; then row_en=8'h01, oe_n=0 for exactly 1000 cycles.
//  3 enable=1 for 2 frames -> row_en steps 01,02,04..80,01; frame_start period 8792 cycles.
//  4 board all-ones, change to all-zeros during row 3 HOLD -> rows 4..7 still shift 24 ones;
//    row 0 of next frame shifts 24 zeros.
//  5 enable=0 during row 2 SHIFT -> row 2 completes LATCH+HOLD, then oe_n=1, row_en=0;
//    enable=1 again -> frame_start pulse, row_en=8'h01 first.
//  6 reset=1 during row 5 SHIFT with sh_cp=1 -> next edge sh_cp=0, ds=0, oe_n=1, row_en=0.

Source files
------------

// File: rtl/led_matrix_scan_driver_if.sv
// Board-to-matrix link: game-side frame/enable inputs and the shift-chain/row pins.
interface led_matrix_scan_driver_if;
  logic            enable;
  logic [7:0][23:0] board;
  logic            ds;
  logic            sh_cp;
  logic            st_cp;
  logic            oe_n;
  logic [7:0]      row_en;
  logic            frame_start;

  modport master (
    output enable, board,
    input  ds, sh_cp, st_cp, oe_n, row_en, frame_start
  );

  modport slave (
    input  enable, board,
    output ds, sh_cp, st_cp, oe_n, row_en, frame_start
  );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// Scans an 8x8 RGB frame row by row into a 24-bit '595 chain, latches it, then lights the row.
// All matrix pins are registered so they change glitch-free, one cycle behind the FSM.
module led_matrix_scan_driver #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned ROW_HOLD = 1000
) (
  input logic                     clk,
  input logic                     reset,
  led_matrix_scan_driver_if.slave bus
);
  localparam int unsigned MaxCnt = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLatch, StHold} scanState_e;

  scanState_e       stateQ, stateD;
  logic [2:0]       rowQ, rowD;
  logic [4:0]       bitQ, bitD;
  logic             phaseQ, phaseD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [23:0]      shiftQ, shiftD;
  logic [7:0][23:0] frameQ, frameD;

  logic       dsQ, dsD, shCpQ, shCpD, stCpQ, stCpD, oeNQ, oeND, frameStartQ, frameStartD;
  logic [7:0] rowEnQ, rowEnD;

  logic divDone, holdDone;
  assign divDone  = (cntQ == CntW'(CLK_DIV - 1));
  assign holdDone = (cntQ == CntW'(ROW_HOLD - 1));

  always_comb begin
    stateD      = stateQ;
    rowD        = rowQ;
    bitD        = bitQ;
    phaseD      = phaseQ;
    cntD        = cntQ;
    shiftD      = shiftQ;
    frameD      = frameQ;
    dsD         = 1'b0;
    shCpD       = 1'b0;
    stCpD       = 1'b0;
    oeND        = 1'b1;
    rowEnD      = 8'h00;
    frameStartD = 1'b0;
    unique case (stateQ)
      StIdle: begin
        rowD = 3'd0;
        if (bus.enable) stateD = StLoad;
      end
      StLoad: begin
        // Snapshot only at row 0 so a frame is never torn by mid-frame board updates
        if (rowQ == 3'd0) begin
          frameD      = bus.board;
          shiftD      = bus.board[0];
          frameStartD = 1'b1;
        end else begin
          shiftD = frameQ[rowQ];
        end
        bitD   = 5'd23;
        phaseD = 1'b0;
        cntD   = '0;
        stateD = StShift;
      end
      StShift: begin
        dsD   = shiftQ[23];
        shCpD = phaseQ;
        if (divDone) begin
          cntD   = '0;
          phaseD = ~phaseQ;
          if (phaseQ) begin
            shiftD = {shiftQ[22:0], 1'b0};
            bitD   = bitQ - 5'd1;
            if (bitQ == 5'd0) stateD = StLatch;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StLatch: begin
        stCpD = 1'b1;
        if (divDone) begin
          cntD   = '0;
          stateD = StHold;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StHold: begin
        oeND   = 1'b0;
        rowEnD = 8'b1 << rowQ;
        if (holdDone) begin
          cntD = '0;
          if (bus.enable) begin
            rowD   = rowQ + 3'd1;
            stateD = StLoad;
          end else begin
            rowD   = 3'd0;
            stateD = StIdle;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= StIdle;
      rowQ        <= 3'd0;
      bitQ        <= 5'd0;
      phaseQ      <= 1'b0;
      cntQ        <= '0;
      shiftQ      <= 24'h0;
      frameQ      <= '0;
      dsQ         <= 1'b0;
      shCpQ       <= 1'b0;
      stCpQ       <= 1'b0;
      oeNQ        <= 1'b1;
      rowEnQ      <= 8'h00;
      frameStartQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      rowQ        <= rowD;
      bitQ        <= bitD;
      phaseQ      <= phaseD;
      cntQ        <= cntD;
      shiftQ      <= shiftD;
      frameQ      <= frameD;
      dsQ         <= dsD;
      shCpQ       <= shCpD;
      stCpQ       <= stCpD;
      oeNQ        <= oeND;
      rowEnQ      <= rowEnD;
      frameStartQ <= frameStartD;
    end
  end

  assign bus.ds          = dsQ;
  assign bus.sh_cp       = shCpQ;
  assign bus.st_cp       = stCpQ;
  assign bus.oe_n        = oeNQ;
  assign bus.row_en      = rowEnQ;
  assign bus.frame_start = frameStartQ;
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver with default CLK_DIV=2, ROW_HOLD=1000.
module tb_led_matrix_scan_driver;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_matrix_scan_driver_if bus ();

  led_matrix_scan_driver #(
    .CLK_DIV (2),
    .ROW_HOLD(1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vecCnt = 0;
  int errCnt = 0;
  int cyc = 0;
  int fsPrev = 0;
  int fsLast = 0;
  int fsCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_start === 1'b1) begin
      fsPrev  <= fsLast;
      fsLast  <= cyc;
      fsCount <= fsCount + 1;
    end
  end

  task automatic wait_oe(input logic val, input int bound, input string what);
    int n;
    n = 0;
    while (bus.oe_n !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus.oe_n !== val) begin
      errCnt++;
      $display("FAIL timeout_%s: oe_n=%b, wanted %b", what, bus.oe_n, val);
    end
  endtask

  // Collects ds at the next 24 sh_cp rising edges, first bit ends up in bits[23]
  task automatic capture_row(output logic [23:0] bits);
    logic prev;
    int got, n;
    bits = 24'h0;
    got  = 0;
    n    = 0;
    prev = bus.sh_cp;
    while (got < 24 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.sh_cp === 1'b1 && prev === 1'b0) begin
        bits = {bits[22:0], bus.ds};
        got++;
      end
      prev = bus.sh_cp;
    end
    if (got < 24) begin
      errCnt++;
      $display("FAIL timeout_capture: got %0d bits, wanted 24", got);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.board  = '0;
    bus.board[0] = 24'h800001;
    repeat (3) @(negedge clk);
    vecCnt++; if (bus.ds !== 1'b0) begin errCnt++; $display("FAIL rst_ds: got %b want 0", bus.ds); end
    vecCnt++; if (bus.sh_cp !== 1'b0) begin errCnt++; $display("FAIL rst_sh_cp: got %b want 0", bus.sh_cp); end
    vecCnt++; if (bus.st_cp !== 1'b0) begin errCnt++; $display("FAIL rst_st_cp: got %b want 0", bus.st_cp); end
    vecCnt++; if (bus.oe_n !== 1'b1) begin errCnt++; $display("FAIL rst_oe_n: got %b want 1", bus.oe_n); end
    vecCnt++; if (bus.row_en !== 8'h00) begin errCnt++; $display("FAIL rst_row_en: got %h want 00", bus.row_en); end
    vecCnt++; if (bus.frame_start !== 1'b0) begin errCnt++; $display("FAIL rst_fs: got %b want 0", bus.frame_start); end
    reset = 1'b0;
    @(negedge clk);
    vecCnt++; if (bus.frame_start !== 1'b0) begin errCnt++; $display("FAIL fs_early: got %b want 0", bus.frame_start); end
    @(negedge clk);
    vecCnt++; if (bus.frame_start !== 1'b1) begin errCnt++; $display("FAIL fs_pulse: got %b want 1", bus.frame_start); end
    vecCnt++; if (bus.oe_n !== 1'b1) begin errCnt++; $display("FAIL oe_after_rst: got %b want 1", bus.oe_n); end
  endtask

  task automatic test_single_row();
    logic [23:0] bits;
    int n, w, bad;
    capture_row(bits);
    vecCnt++; if (bits !== 24'h800001) begin errCnt++; $display("FAIL row0_bits: got %h want 800001", bits); end
    vecCnt++; if (bus.oe_n !== 1'b1) begin errCnt++; $display("FAIL oe_in_shift: got %b want 1", bus.oe_n); end
    n = 0;
    while (bus.st_cp !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    w = 0;
    while (bus.st_cp === 1'b1 && w < 100) begin @(negedge clk); w++; end
    vecCnt++; if (w !== 2) begin errCnt++; $display("FAIL st_cp_width: got %0d want 2", w); end
    vecCnt++; if (bus.oe_n !== 1'b0) begin errCnt++; $display("FAIL hold_start_oe: got %b want 0", bus.oe_n); end
    w = 0;
    bad = 0;
    while (bus.oe_n === 1'b0 && w < 2000) begin
      if (bus.row_en !== 8'h01) bad++;
      @(negedge clk);
      w++;
    end
    vecCnt++; if (w !== 1000) begin errCnt++; $display("FAIL hold_len: got %0d want 1000", w); end
    vecCnt++; if (bad !== 0) begin errCnt++; $display("FAIL hold_row_en: %0d cycles not 01, want 0", bad); end
    vecCnt++; if (bus.row_en !== 8'h00) begin errCnt++; $display("FAIL row_en_off: got %h want 00", bus.row_en); end
  endtask

  task automatic test_scan();
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) begin
      wait_oe(1'b0, 3000, "scan_hold");
      exp = 8'h01 << ((i + 1) % 8);
      vecCnt++; if (bus.row_en !== exp) begin errCnt++; $display("FAIL scan_row_en%0d: got %h want %h", i, bus.row_en, exp); end
      wait_oe(1'b1, 3000, "scan_end");
    end
    vecCnt++; if (fsCount !== 2) begin errCnt++; $display("FAIL fs_count: got %0d want 2", fsCount); end
    vecCnt++; if (fsLast - fsPrev !== 8792) begin errCnt++; $display("FAIL fs_period: got %0d want 8792", fsLast - fsPrev); end
  endtask

  task automatic test_no_tear();
    logic [23:0] bits;
    int n;
    bus.board = '1;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
    if (bus.frame_start !== 1'b1) begin errCnt++; $display("FAIL timeout_frame_start: got 0 want 1"); end
    for (int r = 0; r < 8; r++) begin
      capture_row(bits);
      vecCnt++; if (bits !== 24'hFFFFFF) begin errCnt++; $display("FAIL tear_row%0d: got %h want ffffff", r, bits); end
      if (r == 3) begin
        wait_oe(1'b0, 3000, "row3_hold");
        bus.board = '0;
      end
    end
    capture_row(bits);
    vecCnt++; if (bits !== 24'h000000) begin errCnt++; $display("FAIL next_frame_row0: got %h want 000000", bits); end
  endtask

  task automatic test_enable_drop();
    logic [23:0] bits;
    int w, bad, n;
    capture_row(bits);
    wait_oe(1'b0, 3000, "row1_hold");
    wait_oe(1'b1, 3000, "row1_end");
    repeat (10) @(negedge clk);
    bus.enable = 1'b0;
    wait_oe(1'b0, 3000, "row2_hold");
    vecCnt++; if (bus.row_en !== 8'h04) begin errCnt++; $display("FAIL drop_row_en: got %h want 04", bus.row_en); end
    w = 0;
    while (bus.oe_n === 1'b0 && w < 2000) begin @(negedge clk); w++; end
    vecCnt++; if (w !== 1000) begin errCnt++; $display("FAIL drop_hold_len: got %0d want 1000", w); end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.oe_n !== 1'b1 || bus.row_en !== 8'h00 || bus.sh_cp !== 1'b0 || bus.frame_start !== 1'b0)
        bad++;
      @(negedge clk);
    end
    vecCnt++; if (bad !== 0) begin errCnt++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
    bus.board    = '0;
    bus.board[0] = 24'hA5C33C;
    bus.board[5] = 24'hFFFFFF;
    bus.enable   = 1'b1;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vecCnt++; if (bus.frame_start !== 1'b1) begin errCnt++; $display("FAIL restart_fs: got 0 want 1"); end
    capture_row(bits);
    vecCnt++; if (bits !== 24'hA5C33C) begin errCnt++; $display("FAIL restart_row0: got %h want a5c33c", bits); end
    wait_oe(1'b0, 3000, "restart_hold");
    vecCnt++; if (bus.row_en !== 8'h01) begin errCnt++; $display("FAIL restart_row_en: got %h want 01", bus.row_en); end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    for (int k = 1; k <= 4; k++) begin
      wait_oe(1'b1, 3000, "walk_end");
      wait_oe(1'b0, 3000, "walk_hold");
    end
    vecCnt++; if (bus.row_en !== 8'h10) begin errCnt++; $display("FAIL walk_row4: got %h want 10", bus.row_en); end
    wait_oe(1'b1, 3000, "row4_end");
    n = 0;
    while (bus.sh_cp !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vecCnt++; if (bus.ds !== 1'b1) begin errCnt++; $display("FAIL row5_ds_pre: got %b want 1", bus.ds); end
    reset = 1'b1;
    @(negedge clk);
    vecCnt++; if (bus.sh_cp !== 1'b0) begin errCnt++; $display("FAIL mid_rst_sh_cp: got %b want 0", bus.sh_cp); end
    vecCnt++; if (bus.ds !== 1'b0) begin errCnt++; $display("FAIL mid_rst_ds: got %b want 0", bus.ds); end
    vecCnt++; if (bus.oe_n !== 1'b1) begin errCnt++; $display("FAIL mid_rst_oe_n: got %b want 1", bus.oe_n); end
    vecCnt++; if (bus.row_en !== 8'h00) begin errCnt++; $display("FAIL mid_rst_row_en: got %h want 00", bus.row_en); end
    vecCnt++; if (bus.st_cp !== 1'b0) begin errCnt++; $display("FAIL mid_rst_st_cp: got %b want 0", bus.st_cp); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_scan();
    test_no_tear();
    test_enable_drop();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end
endmodule
